imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer for the synchronous instruction memory (1-cycle registered read, no enable, word address). Owns the fetch PC and issues one word address per cycle. Tracks the single in-flight read and buffers returned words in a 2-entry queue. Presents {pc, instr} to decode with a valid/ready handshake, and handles halt and branch redirect (flush) without losing or duplicating instructions.

Parameters:
ADDR_WIDTH, 10, imem word-address width; depth = 2^ADDR_WIDTH words
RESET_PC, 32'h0000_0000, byte PC fetched first after reset; bits [1:0] must be 0

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
halt  in  1  1 = issue no new fetches; in-flight read still completes
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  new byte PC; bits [1:0] ignored (treated as 0)
imem_addr  out  ADDR_WIDTH  word address to imem, = pc_q[ADDR_WIDTH+1:2]
imem_req  out  1  1 = the address on imem_addr is an issued fetch this cycle
imem_data  in  32  imem read data; holds the word for the address presented the previous cycle
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_pc  out  32  byte PC of head
out_instr  out  32  instruction of head

Behaviour:
- Interface: single clock clk; reset rst is asynchronous, active-high. All state clears immediately on rst assertion.
- State: pc_q[31:0]; inf_valid and inf_pc (in-flight read); 2-entry queue of {pc, instr} with count 0..2.
- Reset values: pc_q = RESET_PC, inf_valid = 0, count = 0. Therefore out_valid = 0, out_pc = 0, out_instr = 0, imem_req = 0 while rst is high, and imem_addr = RESET_PC[ADDR_WIDTH+1:2].
- out_fire = out_valid & out_ready. Head pops on out_fire.
- issue = !rst & !halt & !redirect_valid & ((count + inf_valid - out_fire) < 2). Combinational. imem_req = issue.
- On issue: inf_valid <= 1, inf_pc <= pc_q, pc_q <= pc_q + 4 (32-bit wrap). Otherwise inf_valid <= 0 and pc_q holds.
- Return: when inf_valid is 1 and there is no redirect, push {inf_pc, imem_data} into the queue that cycle. The issue rule guarantees space. Push and pop in the same cycle are legal.
- Latency: address issued in cycle N -> word in queue at the end of N+1 -> out_valid in N+2. No bypass. Sustained throughput is 1 instruction/cycle with out_ready=1.
- Stall (out_ready=0): head holds stable (pc and instr unchanged). Issue stops once count + inf_valid reaches 2. No word is dropped or duplicated.
- Redirect (priority over everything except rst), in the redirect cycle:
  - out_valid is forced to 0, so no fire occurs.
  - The queue is flushed (count <= 0).
  - The returning in-flight word is discarded (inf_valid <= 0).
  - There is no issue.
  - pc_q <= {redirect_pc[31:2], 2'b00}.
  - The next cycle issues the redirect target, provided halt is low.
  - Back-to-back redirects: the last one wins.
- Halt: the in-flight word is still pushed, and queued words still drain. Fetch resumes at pc_q the cycle halt falls. A redirect during halt updates pc_q.
- Address wrap: imem_addr uses pc bits only, so the fetch address wraps at depth 2^ADDR_WIDTH while out_pc keeps the full 32-bit value.
- Reset mid-operation: everything is discarded. After rst deasserts, the first issue is in the next clk cycle, at RESET_PC.

Decomposition:
- Package fetch_pkg holds:
  - INSTR_W = 32
  - fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr;}
  - NOP_INSTR = 32'h0000_0013
- Sub-module fetch_queue: a 2-entry FIFO of fetch_entry_t with push, pop, flush, count and head outputs, plus async rst.
- imem_fetch_ctrl contains the PC, in-flight tracking and issue logic.

Test Plan:
- Stream: memory word[i] = 32'h1000_0000+i, out_ready=1, release rst -> out_valid first in cycle 2; out_pc 0,4,8,... with instr 10000000,10000001,... on consecutive cycles; imem_req=1 every cycle.
- Stall: hold out_ready=0 for 5 cycles after the first valid -> head stays pc=0/instr=10000000; imem_req drops after 2 outstanding. On release the sequence continues 0,4,8,... with no gap or duplicate.
- Redirect: while streaming, assert redirect_valid with redirect_pc=32'h0000_0103 when out_pc=8 -> out_valid=0 that cycle; the next valid output is pc=32'h100 with instr=word[64], 2 cycles after redirect_req issue. No word from pc 12/16 ever appears.
- Halt: assert halt for 4 cycles mid-stream -> at most 2 further words emitted, then out_valid=0. After release, the PCs resume in order without a skip.
- Wrap: ADDR_WIDTH=4, stream 18 words -> imem_addr goes 15 -> 0. out_pc=64 carries instr=word[0].
- Async reset mid-stream: pulse rst between clock edges -> out_valid and imem_req go 0 immediately. After release, the first output is pc=RESET_PC with instr=word[0].

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch path.
package fetch_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} between the imem return path and decode.
// Push and pop may coincide; flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '{pc: '0, instr: NOP_INSTR};
      mem[1] <= '{pc: '0, instr: NOP_INSTR};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one word read per cycle to a
// 1-cycle imem, and buffers returned words for decode.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_req,
  input  logic [31:0]           imem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_instr
);

  logic [31:0]  pc_q;
  logic [31:0]  inf_pc;
  logic         inf_valid;
  logic [1:0]   count;
  logic [2:0]   occ;
  logic         out_fire;
  logic         issue;
  logic         push;
  fetch_entry_t head;

  fetch_queue u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (out_fire),
    .flush (redirect_valid),
    .din   ('{pc: inf_pc, instr: imem_data}),
    .count (count),
    .head  (head)
  );

  assign out_valid = !redirect_valid && (count != 2'd0);
  assign out_fire  = out_valid && out_ready;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : '0;

  // Occupancy counts the in-flight word so a returning read always has a slot.
  assign occ      = {1'b0, count} + {2'b0, inf_valid} - {2'b0, out_fire};
  assign issue    = !rst && !halt && !redirect_valid && (occ < 3'd2);
  assign push     = inf_valid && !redirect_valid;
  assign imem_req = issue;
  assign imem_addr = pc_q[ADDR_WIDTH+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      inf_pc    <= '0;
      inf_valid <= 1'b0;
    end else begin
      inf_valid <= issue;
      if (issue) begin
        inf_pc <= pc_q;
        pc_q   <= pc_q + 32'd4;
      end else if (redirect_valid) begin
        pc_q <= redirect_pc & ~32'h3;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a 1K-word and a 16-word instance
// run the same stimulus, each with its own registered-read memory model.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b1;

  logic [9:0]  imem_addr;
  logic        imem_req;
  logic [31:0] imem_data = '0;
  logic        out_valid;
  logic [31:0] out_pc, out_instr;

  logic [3:0]  imem_addr_w;
  logic        imem_req_w;
  logic [31:0] imem_data_w = '0;
  logic        out_valid_w;
  logic [31:0] out_pc_w, out_instr_w;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [127:0] exp_q[$];
  logic [127:0] obs_q[$];
  int           obs_cyc[$];

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.ADDR_WIDTH(10), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_data(imem_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  imem_fetch_ctrl #(.ADDR_WIDTH(4), .RESET_PC(32'h0)) dut_w (
    .clk(clk), .rst(rst), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr_w), .imem_req(imem_req_w),
    .imem_data(imem_data_w), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_pc(out_pc_w), .out_instr(out_instr_w)
  );

  // word[i] = 1000_0000 + i, registered read
  always @(posedge clk) begin
    imem_data   <= 32'h1000_0000 + {22'b0, imem_addr};
    imem_data_w <= 32'h1000_0000 + {28'b0, imem_addr_w};
  end

  function automatic logic [127:0] exp_entry(input logic [31:0] pc);
    logic [31:0] w10, w4;
    w10 = 32'h1000_0000 + {22'b0, pc[11:2]};
    w4  = 32'h1000_0000 + {28'b0, pc[5:2]};
    return {pc, w10, pc, w4};
  endfunction

  task automatic tick();
    #1;
    if (out_valid && out_ready) begin
      obs_q.push_back({out_pc, out_instr, out_pc_w, out_instr_w});
      obs_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL reset_imem_req got %b exp 0", imem_req); else passed++;
    total++; if (out_pc !== 32'h0) $display("FAIL reset_out_pc got %h exp 0", out_pc); else passed++;
    total++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr got %h exp 0", out_instr); else passed++;
    total++; if (imem_addr !== 10'h0) $display("FAIL reset_imem_addr got %h exp 0", imem_addr); else passed++;
  endtask

  task automatic test_stream();
    logic [127:0] e, o;
    do_reset();
    for (int i = 0; i < 10; i++) exp_q.push_back(exp_entry(32'(i * 4)));
    for (int c = 0; c < 12; c++) begin
      #1;
      total++; if (imem_req !== 1'b1) $display("FAIL stream_req c%0d got %b exp 1", c, imem_req); else passed++;
      total++; if (out_valid !== (c >= 2)) $display("FAIL stream_valid c%0d got %b exp %b", c, out_valid, c >= 2); else passed++;
      tick();
    end
    total++; if (obs_cyc.size() == 0 || obs_cyc[0] != 2) $display("FAIL stream_latency got %0d exp 2", obs_cyc.size() ? obs_cyc[0] : -1); else passed++;
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL stream_count got %0d exp %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
      total++; if (o !== e) $display("FAIL stream_word got %h exp %h", o, e); else passed++;
    end
  endtask

  task automatic test_stall();
    logic [127:0] e, o;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) exp_q.push_back(exp_entry(32'(i * 4)));
    for (int c = 0; c < 17; c++) begin
      out_ready = (c >= 7);
      #1;
      if (c <= 6) begin
        total++; if (imem_req !== (c < 2)) $display("FAIL stall_req c%0d got %b exp %b", c, imem_req, c < 2); else passed++;
      end
      if (c >= 2 && c <= 6) begin
        total++; if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0, 32'h1000_0000})
          $display("FAIL stall_head c%0d got %b/%h/%h exp 1/0/10000000", c, out_valid, out_pc, out_instr); else passed++;
      end
      tick();
    end
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL stall_count got %0d exp %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
      total++; if (o !== e) $display("FAIL stall_word got %h exp %h", o, e); else passed++;
    end
  endtask

  task automatic test_redirect();
    logic [127:0] e, o;
    int first_new;
    do_reset();
    exp_q.push_back(exp_entry(32'h0));
    exp_q.push_back(exp_entry(32'h4));
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_entry(32'h100 + 32'(i * 4)));
    for (int c = 0; c < 11; c++) begin
      #1;
      if (c == 4) begin
        total++; if (out_pc !== 32'h8) $display("FAIL redir_pre_pc got %h exp 8", out_pc); else passed++;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL redir_valid got %b exp 0", out_valid); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL redir_req got %b exp 0", imem_req); else passed++;
      end
      if (c == 5) begin
        total++; if ({imem_req, imem_addr} !== {1'b1, 10'h40}) $display("FAIL redir_issue got %b/%h exp 1/040", imem_req, imem_addr); else passed++;
      end
      if (c == 6) begin
        total++; if (out_valid !== 1'b0) $display("FAIL redir_gap got %b exp 0", out_valid); else passed++;
      end
      tick();
      redirect_valid = 1'b0;
    end
    first_new = (obs_cyc.size() > 2) ? obs_cyc[2] : -1;
    total++; if (first_new != 7) $display("FAIL redir_latency got %0d exp 7", first_new); else passed++;
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL redir_count got %0d exp %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
      total++; if (o !== e) $display("FAIL redir_word got %h exp %h", o, e); else passed++;
    end
  endtask

  task automatic test_halt();
    logic [127:0] e, o;
    do_reset();
    for (int i = 0; i < 9; i++) exp_q.push_back(exp_entry(32'(i * 4)));
    for (int c = 0; c < 15; c++) begin
      halt = (c >= 5 && c <= 8);
      #1;
      if (c >= 5 && c <= 8) begin
        total++; if (imem_req !== 1'b0) $display("FAIL halt_req c%0d got %b exp 0", c, imem_req); else passed++;
      end
      if (c >= 7 && c <= 10) begin
        total++; if (out_valid !== 1'b0) $display("FAIL halt_drain c%0d got %b exp 0", c, out_valid); else passed++;
      end
      if (c == 9) begin
        total++; if ({imem_req, imem_addr} !== {1'b1, 10'h5}) $display("FAIL halt_resume got %b/%h exp 1/005", imem_req, imem_addr); else passed++;
      end
      tick();
    end
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL halt_count got %0d exp %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
      total++; if (o !== e) $display("FAIL halt_word got %h exp %h", o, e); else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [127:0] e, o;
    do_reset();
    for (int i = 0; i < 18; i++) exp_q.push_back(exp_entry(32'(i * 4)));
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c == 15) begin
        total++; if (imem_addr_w !== 4'hf) $display("FAIL wrap_addr15 got %h exp f", imem_addr_w); else passed++;
      end
      if (c == 16) begin
        total++; if (imem_addr_w !== 4'h0) $display("FAIL wrap_addr0 got %h exp 0", imem_addr_w); else passed++;
      end
      tick();
    end
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL wrap_count got %0d exp %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
      total++; if (o !== e) $display("FAIL wrap_word got %h exp %h", o, e); else passed++;
    end
  endtask

  task automatic test_async_reset();
    logic [127:0] e, o;
    do_reset();
    for (int c = 0; c < 6; c++) tick();
    #2;
    rst = 1'b1;
    #1;
    total++; if ({out_valid, imem_req, out_valid_w, imem_req_w} !== 4'b0)
      $display("FAIL arst_outputs got %b exp 0000", {out_valid, imem_req, out_valid_w, imem_req_w}); else passed++;
    total++; if (out_pc !== 32'h0) $display("FAIL arst_out_pc got %h exp 0", out_pc); else passed++;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 6; i++) exp_q.push_back(exp_entry(32'(i * 4)));
    for (int c = 0; c < 8; c++) tick();
    total++; if (obs_cyc.size() == 0 || obs_cyc[0] != 2) $display("FAIL arst_latency got %0d exp 2", obs_cyc.size() ? obs_cyc[0] : -1); else passed++;
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL arst_count got %0d exp %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
      total++; if (o !== e) $display("FAIL arst_word got %h exp %h", o, e); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
